// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store unit. Converts RV32I load/store requests
//               into a req/ack word-bus transaction with byte enables,
//               sign/zero-extends load data, stalls the pipeline while the
//               bus is busy, and flags misaligned/illegal accesses and
//               bus timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       load_data_out,
  output logic              done_out,
  output logic              stall_out,
  output logic              fault_out
);

  // Timeout counter width; at least one bit even for tiny timeouts.
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  // funct3[1:0] size encoding
  localparam logic [1:0] c_SZ_B = 2'b00;
  localparam logic [1:0] c_SZ_H = 2'b01;
  localparam logic [1:0] c_SZ_W = 2'b10;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic               r_bus_req;
  logic               r_bus_we;
  logic [ADDR_W-1:0]  r_bus_addr;
  logic [3:0]         r_bus_be;
  logic [31:0]        r_bus_wdata;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic               r_is_load;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_load_data;
  logic               r_done;
  logic               r_fault;

  logic               w_access;
  logic               w_both;
  logic               w_f3_ok;
  logic               w_misaligned;
  logic               w_illegal;
  logic               w_accept;
  logic               w_timeout;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [7:0]         w_ld_byte;
  logic [15:0]        w_ld_half;
  logic [31:0]        w_ld_ext;

  // Classify the incoming request as legal, illegal/misaligned, or absent.
  always_comb begin
    w_access = valid_in & (mem_read_in | mem_write_in);
    w_both   = mem_read_in & mem_write_in;
    case (funct3_in)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = mem_read_in & ~mem_write_in;
      default:                w_f3_ok = 1'b0;
    endcase
    w_misaligned = ((funct3_in[1:0] == c_SZ_H) & addr_in[0]) |
                   ((funct3_in[1:0] == c_SZ_W) & (addr_in[1:0] != 2'b00));
    w_illegal    = w_access & (w_both | ~w_f3_ok | w_misaligned);
    w_accept     = w_access & ~w_both & w_f3_ok & ~w_misaligned;
  end

  // Byte enables and lane-replicated write data; loads read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (mem_write_in) begin
      case (funct3_in[1:0])
        c_SZ_B: begin
          w_be    = 4'b0001 << addr_in[1:0];
          w_wdata = {4{wdata_in[7:0]}};
        end
        c_SZ_H: begin
          w_be    = addr_in[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata_in[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata_in;
        end
      endcase
    end
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    case (r_off)
      2'd0:    w_ld_byte = bus_rdata[7:0];
      2'd1:    w_ld_byte = bus_rdata[15:8];
      2'd2:    w_ld_byte = bus_rdata[23:16];
      default: w_ld_byte = bus_rdata[31:24];
    endcase
    w_ld_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_ext = {24'h0, w_ld_byte};
      3'b101:  w_ld_ext = {16'h0, w_ld_half};
      default: w_ld_ext = bus_rdata;
    endcase
  end

  // Timeout fires on the last allowed BUSY cycle if no ack arrives.
  always_comb begin
    w_timeout = (r_state == c_ST_BUSY) & ~bus_ack & (r_cnt == c_CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DONE always returns to IDLE since the pipeline advances.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept) w_state_nxt = c_ST_BUSY;
      c_ST_BUSY: if (bus_ack || w_timeout) w_state_nxt = c_ST_DONE;
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: stall while a legal access is being accepted or in flight.
  always_comb begin
    stall_out     = 1'b0;
    case (r_state)
      c_ST_IDLE: stall_out = w_accept;
      c_ST_BUSY: stall_out = 1'b1;
      default:   stall_out = 1'b0;
    endcase
    bus_req       = r_bus_req;
    bus_we        = r_bus_we;
    bus_addr      = r_bus_addr;
    bus_be        = r_bus_be;
    bus_wdata     = r_bus_wdata;
    load_data_out = r_load_data;
    done_out      = r_done;
    fault_out     = r_fault;
  end

  // Bus registers, capture of access attributes, timeout counter and
  // the done/fault pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_is_load   <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= 32'h0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_write_in;
            r_bus_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_funct3    <= funct3_in;
            r_off       <= addr_in[1:0];
            r_is_load   <= mem_read_in;
          end else if (w_illegal) begin
            r_fault <= 1'b1;
          end
        end
        c_ST_BUSY: begin
          if (bus_ack || w_timeout) begin
            // Release the bus; everything else reports in DONE.
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0;
            r_done      <= bus_ack;
            r_fault     <= ~bus_ack;
            r_load_data <= (bus_ack && r_is_load) ? w_ld_ext : 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // DONE: result is visible this cycle only.
          r_load_data <= 32'h0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] load_data_out;
  logic        done_out;
  logic        stall_out;
  logic        fault_out;

  int ntests = 0;
  int nfail  = 0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .funct3_in    (funct3_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .load_data_out(load_data_out),
    .done_out     (done_out),
    .stall_out    (stall_out),
    .fault_out    (fault_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_in     = 1'b1;
    mem_read_in  = rd;
    mem_write_in = wr;
    funct3_in    = f3;
    addr_in      = a;
    wdata_in     = wd;
  endtask

  task automatic idle_in();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    funct3_in    = 3'b000;
    addr_in      = 32'h0;
    wdata_in     = 32'h0;
  endtask

  // Legal access; ack arrives 'dly' cycles after the first bus_req cycle.
  task automatic run_ok(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int dly,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_ld);
    drive(rd, wr, f3, a, wd);
    #1 chk({tag, ".stall_accept"}, {31'h0, stall_out}, 32'h1);
    tick();
    chk({tag, ".bus_req"}, {31'h0, bus_req}, 32'h1);
    chk({tag, ".bus_we"},  {31'h0, bus_we}, {31'h0, wr});
    chk({tag, ".bus_addr"}, bus_addr, e_addr);
    chk({tag, ".bus_be"},  {28'h0, bus_be}, {28'h0, e_be});
    if (wr) chk({tag, ".bus_wdata"}, bus_wdata, e_wdata);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, ".stall_busy"}, {31'h0, stall_out}, 32'h1);
    end
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    #1 chk({tag, ".stall_ack"}, {31'h0, stall_out}, 32'h1);
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    chk({tag, ".done"},      {31'h0, done_out}, 32'h1);
    chk({tag, ".fault0"},    {31'h0, fault_out}, 32'h0);
    chk({tag, ".stall_done"},{31'h0, stall_out}, 32'h0);
    chk({tag, ".req_drop"},  {31'h0, bus_req}, 32'h0);
    chk({tag, ".load_data"}, load_data_out, e_ld);
    idle_in();
    tick();
    chk({tag, ".done_clr"},  {31'h0, done_out}, 32'h0);
  endtask

  // Illegal or misaligned access: no bus activity, one fault pulse.
  task automatic run_bad(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a);
    drive(rd, wr, f3, a, 32'hFFFF_FFFF);
    #1 chk({tag, ".stall"}, {31'h0, stall_out}, 32'h0);
    tick();
    idle_in();
    chk({tag, ".fault"},   {31'h0, fault_out}, 32'h1);
    chk({tag, ".no_req"},  {31'h0, bus_req}, 32'h0);
    chk({tag, ".no_we"},   {31'h0, bus_we}, 32'h0);
    chk({tag, ".ld_zero"}, load_data_out, 32'h0);
    tick();
    chk({tag, ".fault_clr"}, {31'h0, fault_out}, 32'h0);
    chk({tag, ".no_req2"},   {31'h0, bus_req}, 32'h0);
  endtask

  initial begin
    rst       = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    idle_in();
    tick();
    tick();
    chk("reset.bus_req", {31'h0, bus_req}, 32'h0);
    chk("reset.done",    {31'h0, done_out}, 32'h0);
    chk("reset.fault",   {31'h0, fault_out}, 32'h0);
    chk("reset.stall",   {31'h0, stall_out}, 32'h0);
    chk("reset.ld",      load_data_out, 32'h0);
    rst = 1'b1;
    tick();

    // LW with ack two cycles after the request
    run_ok("lw100", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2,
           32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    // Sub-word loads from the same word
    run_ok("lb103",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 1,
           32'h100, 4'b1111, 32'h0, 32'hFFFF_FF80);
    run_ok("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 1,
           32'h100, 4'b1111, 32'h0, 32'h0000_0080);
    run_ok("lhu102", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_FF7F, 1,
           32'h100, 4'b1111, 32'h0, 32'h0000_80FF);
    run_ok("lh102",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_FF7F, 1,
           32'h100, 4'b1111, 32'h0, 32'hFFFF_80FF);
    run_ok("lb100",  1, 0, 3'b000, 32'h100, 32'h0, 32'h80FF_FF7F, 1,
           32'h100, 4'b1111, 32'h0, 32'h0000_007F);
    // Stores: load_data stays 0
    run_ok("sb201", 0, 1, 3'b000, 32'h201, 32'h0000_00AB, 32'h5555_5555, 1,
           32'h200, 4'b0010, 32'hABAB_ABAB, 32'h0);
    run_ok("sh202", 0, 1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 1,
           32'h200, 4'b1100, 32'h1234_1234, 32'h0);
    run_ok("sh200", 0, 1, 3'b001, 32'h200, 32'hAAAA_5678, 32'h0, 1,
           32'h200, 4'b0011, 32'h5678_5678, 32'h0);

    // Misaligned and illegal accesses
    run_bad("lw102_mis", 1, 0, 3'b010, 32'h102);
    run_bad("sh101_mis", 0, 1, 3'b001, 32'h101);
    run_bad("ld_f3_011", 1, 0, 3'b011, 32'h100);
    run_bad("sb_f3_100", 0, 1, 3'b100, 32'h100);
    run_bad("rd_and_wr", 1, 1, 3'b010, 32'h100);

    // Timeout: no ack for TIMEOUT_CYCLES BUSY cycles
    drive(1, 0, 3'b010, 32'h400, 32'h0);
    tick();
    chk("to.req_start", {31'h0, bus_req}, 32'h1);
    for (int i = 0; i < 63; i++) tick();
    chk("to.req_last",  {31'h0, bus_req}, 32'h1);
    chk("to.stall_last",{31'h0, stall_out}, 32'h1);
    chk("to.fault_early",{31'h0, fault_out}, 32'h0);
    tick();
    chk("to.req_drop",  {31'h0, bus_req}, 32'h0);
    chk("to.fault",     {31'h0, fault_out}, 32'h1);
    chk("to.done",      {31'h0, done_out}, 32'h0);
    chk("to.stall",     {31'h0, stall_out}, 32'h0);
    chk("to.ld",        load_data_out, 32'h0);
    idle_in();
    tick();
    chk("to.fault_clr", {31'h0, fault_out}, 32'h0);
    run_ok("lw_after_to", 1, 0, 3'b010, 32'h404, 32'h0, 32'h1234_5678, 1,
           32'h404, 4'b1111, 32'h0, 32'h1234_5678);

    // Reset while BUSY drops bus_req at once
    drive(1, 0, 3'b010, 32'h500, 32'h0);
    tick();
    chk("rst.req_before", {31'h0, bus_req}, 32'h1);
    #2;
    idle_in();
    rst = 1'b0;
    #1;
    chk("rst.req_now", {31'h0, bus_req}, 32'h0);
    chk("rst.stall",   {31'h0, stall_out}, 32'h0);
    tick();
    chk("rst.done",    {31'h0, done_out}, 32'h0);
    chk("rst.fault",   {31'h0, fault_out}, 32'h0);
    rst = 1'b1;
    tick();
    chk("rst.idle_req", {31'h0, bus_req}, 32'h0);
    run_ok("sw300", 0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 1,
           32'h300, 4'b1111, 32'hCAFE_F00D, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits in the MEM stage, between the EX/MEM pipeline register and the data memory.
- Converts RV32I load/store requests into a req/ack word-bus transaction with byte enables.
- Sign/zero-extends load data and requests a pipeline stall while the bus is busy.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT_CYCLES, 64, max cycles waiting for bus_ack before fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
valid_in  in  1  EX/MEM holds a valid instruction
mem_read_in  in  1  load request
mem_write_in  in  1  store request
funct3_in  in  3  access size/sign (RV32I encoding)
addr_in  in  ADDR_W  byte address (alu_result_mem)
wdata_in  in  32  store data (forwarded rs2)
bus_req  out  1  bus request, held until ack
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  bus completion, 1-cycle pulse
bus_rdata  in  32  read word, valid with bus_ack
load_data_out  out  32  extended load result, valid while done_out = 1
done_out  out  1  1-cycle pulse: access completed
stall_out  out  1  freeze IF/ID/EX and EX/MEM
fault_out  out  1  1-cycle pulse: misaligned, illegal or timeout

Behaviour:

Reset (rst = 0, asynchronous):
- state = IDLE.
- All outputs 0, including bus_req, load_data_out and timeout counter.
- Reset mid-transaction drops bus_req immediately; no done_out or fault_out is produced.

Access decode:
- An access is valid_in & (mem_read_in | mem_write_in).
- Illegal if both read and write are asserted.
- Illegal funct3: loads other than 000/001/010/100/101; stores other than 000/001/010.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.

States: IDLE, BUSY, DONE.

IDLE:
- Legal, aligned access:
  - Capture address, size, sign and write flag; drive bus signals registered.
  - bus_req = 1 from the next cycle; go to BUSY.
  - stall_out = 1 combinationally in this cycle.
- Illegal or misaligned access:
  - No bus request; fault_out = 1 the next cycle; stay in IDLE.
  - stall_out = 0, so the instruction proceeds; the store is suppressed and load_data_out = 0.
- No access: outputs idle, stall_out = 0.

BUSY:
- stall_out = 1; bus_req/bus_we/bus_addr/bus_be/bus_wdata stay stable.
- Timeout counter increments every cycle.
- On bus_ack:
  - Drop bus_req the next cycle.
  - Register load_data_out (loads only; stores leave 0).
  - Go to DONE.
  - stall_out stays 1 in the ack cycle.
- Counter reaches TIMEOUT_CYCLES - 1 without ack:
  - Drop bus_req; fault_out pulse; load_data_out = 0.
  - Go to DONE.
- bus_ack is ignored in IDLE and DONE.

DONE:
- done_out = 1, or fault_out on timeout; stall_out = 0.
- The pipeline advances at the end of this cycle.
- valid_in is ignored, because the same instruction is still present.
- Go to IDLE unconditionally.

Store lanes (o = addr[1:0]):
- SB: be = 4'b0001 << o; wdata = {4{wdata_in[7:0]}}.
- SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata_in[15:0]}}.
- SW: be = 4'b1111; wdata = wdata_in.

Loads:
- bus_be = 4'b1111 and bus_we = 0.
- Select the byte at lane o, or the half at lane addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Latency:
- Minimum 3 cycles of stall relief: accept cycle, ack cycle with ack arriving the cycle after req, then DONE.
- A back-to-back access is accepted in the IDLE cycle following DONE.

Test Plan:
- LW addr 0x100, bus_ack 2 cycles after req with rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, stall held until ack cycle; DONE cycle gives done_out = 1, load_data_out 0xDEADBEEF, stall_out = 0.
- LB at 0x103, rdata 0x80FF_FF7F -> load_data_out 0xFFFFFF80; LBU same access -> 0x00000080; LHU at 0x102 -> 0x000080FF.
- SB data 0x000000AB at 0x201 -> bus_we = 1, bus_addr 0x200, be 0010, wdata 0xABABABAB; SH 0x1234 at 0x202 -> be 1100, wdata 0x12341234.
- LW at 0x102 -> no bus_req, fault_out pulse, stall_out never asserted; SH at 0x101 -> no write, fault_out pulse.
- Load with no bus_ack for TIMEOUT_CYCLES -> bus_req drops, fault_out = 1, stall_out = 0 in DONE, returns to IDLE; a following valid LW completes normally.
- rst low while in BUSY with bus_req = 1 -> bus_req = 0 at once, no done/fault; after release a new SW to 0x300 is accepted and completes.
